regfile: RTL and testbench
==========================

# regfile

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit port and beside the decoder. The decoder reads source operands and their pending-producer tags here, and marks each issued destination register as owned by a ROB entry. The ROB writes committed results back here. A ROB flush (`clear_all`) drops every pending tag so that later reads return committed architectural state.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers; x0 is hardwired to zero.
- `REG_ID_BIT`, 5: register index width.
- `ROB_WIDTH_BIT`, 4: ROB entry index (tag) width.

Ports:
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  reset: synchronous, active-high.
- `rdy_in`  in  1  global enable; when low, all state is held.
- `issue_en`  in  1  the decoder issues an instruction with a destination this cycle.
- `issue_rd`  in  REG_ID_BIT  destination register of the issued instruction.
- `issue_rob_id`  in  ROB_WIDTH_BIT  ROB entry allocated to that instruction.
- `rs1_id`, `rs2_id`  in  REG_ID_BIT  source register indices (combinational read).
- `rs1_busy`, `rs2_busy`  out  1  source has a pending producer in the ROB.
- `rs1_reorder`, `rs2_reorder`  out  ROB_WIDTH_BIT  tag of the pending producer; 0 when not busy.
- `rs1_value`, `rs2_value`  out  32  committed value; 0 when busy.
- `commit_en`  in  1  the ROB commits a result this cycle.
- `commit_reg_id`  in  REG_ID_BIT  destination register of the committed instruction.
- `commit_rob_id`  in  ROB_WIDTH_BIT  ROB entry being committed.
- `commit_value`  in  32  committed result.
- `clear_all`  in  1  misprediction flush from the ROB.

## Operation
State per register i: `value[i]` (32 bits), `busy[i]`, `reorder[i]` (ROB_WIDTH_BIT bits).

Reset (`rst_in` high at an edge):
- All `value`, `busy` and `reorder` fields become 0.
- Reset overrides `rdy_in` and every other input.

When `rdy_in` is low, no state changes. Reads still follow the combinational rules below.

Commit (at an edge with `rdy_in`=1, `commit_en`=1, `commit_reg_id`≠0):
- `value[r]` <= `commit_value`.
- If `busy[r]` and `reorder[r]`==`commit_rob_id`, then `busy[r]` <= 0.
- If the tag differs, `busy[r]` and `reorder[r]` are unchanged, because a younger producer still owns r.

Issue (at an edge with `rdy_in`=1, `issue_en`=1, `issue_rd`≠0, `clear_all`=0):
- `busy[rd]` <= 1 and `reorder[rd]` <= `issue_rob_id`.

Flush (at an edge with `rdy_in`=1, `clear_all`=1):
- All `busy` <= 0.
- The issue in that cycle is ignored.
- A simultaneous commit's value write is still performed.

Simultaneous events:
- Issue and commit to the same register in one cycle: the value write happens, and issue wins for `busy`/`reorder` (result is busy=1, tag=`issue_rob_id`).
- Commit and issue to different registers: both take effect.

Register x0:
- Writes, issues and commits to x0 are ignored.
- Reads of x0 return busy=0, reorder=0, value=0.

Read port (combinational, identical for rs1 and rs2, shown for index s):
1. If s==0: busy=0, reorder=0, value=0.
2. Else if `commit_en`&`rdy_in`, `commit_reg_id`==s, `busy[s]`, and `reorder[s]`==`commit_rob_id`: bypass, giving busy=0, reorder=0, value=`commit_value`.
3. Else if `busy[s]`: busy=1, reorder=`reorder[s]`, value=0.
4. Else: busy=0, reorder=0, value=`value[s]`.

Other read rules:
- Issue in the current cycle never affects that cycle's reads. For `rs1_id`==`issue_rd`, the decoder sees the older mapping.
- `clear_all` does not bypass; reads reflect the flush from the next cycle.

## Timing
- Read latency is 0 cycles (combinational from `rs*_id` and state), including the commit bypass.
- Issue, commit and flush take effect on state at the rising edge; they are visible on reads from the following cycle.
- There is no handshake. The decoder guarantees at most one issue per cycle, and the ROB guarantees at most one commit per cycle.
- ROB tags wrap modulo 2^ROB_WIDTH_BIT. Tag comparison is plain equality, with no age ordering.
- Reset mid-operation discards all pending tags and values at that edge.

## Test plan
- **Reset:** after reset, read x5 and x31 → busy=0, reorder=0, value=0. Commit x0 with value 0xDEAD, then read x0 → value=0.
- **Issue then commit:**
  - Issue x3 tag 2; next cycle read x3 → busy=1, reorder=2, value=0.
  - Commit x3 tag 2 value 0x1234; in that same cycle the read shows busy=0, value=0x1234 (bypass).
  - Next cycle: busy=0, value=0x1234.
- **Stale commit:** issue x4 tag 1, then issue x4 tag 5, then commit x4 tag 1 value 7 → x4 stays busy=1, reorder=5. After that commit, a commit tag 5 value 9 → busy=0, value=9.
- **Same-cycle issue and commit:** x6 is busy with tag 3; in one cycle commit x6 tag 3 value 0xAA and issue x6 tag 4 → next cycle busy=1, reorder=4. After a later flush, value=0xAA.
- **Flush:** issue x1 tag 0, x2 tag 1 and x7 tag 2, then assert `clear_all` together with issue x8 tag 3 → next cycle x1, x2, x7 and x8 all busy=0, with their previous committed values.
- **rdy_in low:** hold `rdy_in`=0 while issue x9 tag 6 and commit x10 value 5 are applied → no state change, and the x10 read shows no bypass. Raise `rdy_in` for one cycle → both take effect.

Source files
------------

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Brief    : Architectural register file with per-register rename tags.
//            Decoder reads operands plus pending-producer tags and claims
//            destinations; ROB commits results and can flush all tags.
// Revision : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int REG_NUM       = 32,
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_en,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    input  logic [REG_ID_BIT-1:0]    rs1_id,
    input  logic [REG_ID_BIT-1:0]    rs2_id,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_reorder,
    output logic [ROB_WIDTH_BIT-1:0] rs2_reorder,
    output logic [31:0]              rs1_value,
    output logic [31:0]              rs2_value,
    input  logic                     commit_en,
    input  logic [REG_ID_BIT-1:0]    commit_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [31:0]              commit_value,
    input  logic                     clear_all
);

    localparam int c_DATA_W = 32;

    logic [c_DATA_W-1:0]      r_value   [REG_NUM];
    logic                     r_busy    [REG_NUM];
    logic [ROB_WIDTH_BIT-1:0] r_reorder [REG_NUM];

    // Commit and issue are only meaningful when enabled and not aimed at x0.
    logic w_commit_act;
    logic w_issue_act;

    always_comb w_commit_act = rdy_in && commit_en && (commit_reg_id != '0);
    always_comb w_issue_act  = rdy_in && issue_en && (issue_rd != '0) && !clear_all;

    // Per-register state update: commit first, then issue/flush override busy/tag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i]   <= '0;
                r_busy[i]    <= 1'b0;
                r_reorder[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                // A commit always lands its value; it releases busy only if
                // it is still the newest producer of this register.
                if (w_commit_act && (commit_reg_id == REG_ID_BIT'(i))) begin
                    r_value[i] <= commit_value;
                    if (r_busy[i] && (r_reorder[i] == commit_rob_id)) begin
                        r_busy[i] <= 1'b0;
                    end
                end
                // Flush drops every tag; otherwise a same-cycle issue wins
                // over the commit for the busy/tag fields.
                if (clear_all) begin
                    r_busy[i] <= 1'b0;
                end else if (w_issue_act && (issue_rd == REG_ID_BIT'(i))) begin
                    r_busy[i]    <= 1'b1;
                    r_reorder[i] <= issue_rob_id;
                end
            end
        end
    end

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_read_port
            logic [REG_ID_BIT-1:0]    w_id;
            logic                     w_bypass;
            logic                     w_busy;
            logic [ROB_WIDTH_BIT-1:0] w_reorder;
            logic [c_DATA_W-1:0]      w_value;

            assign w_id = (p == 0) ? rs1_id : rs2_id;

            // Same-cycle commit of the exact pending producer is forwarded.
            always_comb w_bypass = commit_en && rdy_in && (commit_reg_id == w_id)
                                   && r_busy[w_id] && (r_reorder[w_id] == commit_rob_id);

            // Source lookup: x0, then commit bypass, then pending tag, then value.
            always_comb begin
                w_busy    = 1'b0;
                w_reorder = '0;
                w_value   = '0;
                if (w_id == '0) begin
                    w_value = '0;
                end else if (w_bypass) begin
                    w_value = commit_value;
                end else if (r_busy[w_id]) begin
                    w_busy    = 1'b1;
                    w_reorder = r_reorder[w_id];
                end else begin
                    w_value = r_value[w_id];
                end
            end
        end
    endgenerate

    assign rs1_busy    = g_read_port[0].w_busy;
    assign rs1_reorder = g_read_port[0].w_reorder;
    assign rs1_value   = g_read_port[0].w_value;
    assign rs2_busy    = g_read_port[1].w_busy;
    assign rs2_reorder = g_read_port[1].w_reorder;
    assign rs2_value   = g_read_port[1].w_value;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Brief    : Self-checking bench for regfile: directed vector table plus
//            randomized traffic against a behavioural register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_reorder;
    logic [3:0]  rs2_reorder;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        commit_en;
    logic [4:0]  commit_reg_id;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        clear_all;

    int tests = 0;
    int fails = 0;

    regfile #(.REG_NUM(32), .REG_ID_BIT(5), .ROB_WIDTH_BIT(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .issue_en      (issue_en),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_reorder   (rs1_reorder),
        .rs2_reorder   (rs2_reorder),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .commit_en     (commit_en),
        .commit_reg_id (commit_reg_id),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .clear_all     (clear_all)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        ie;
        logic [4:0]  ird;
        logic [3:0]  itag;
        logic        ce;
        logic [4:0]  crd;
        logic [3:0]  ctag;
        logic [31:0] cval;
        logic        clr;
        logic [4:0]  s1;
        logic        b1;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic [4:0]  s2;
        logic        b2;
        logic [3:0]  t2;
        logic [31:0] v2;
    } vec_t;

    vec_t vecs[$];

    // Behavioural architectural state.
    logic [31:0] m_value [32];
    logic        m_busy  [32];
    logic [3:0]  m_tag   [32];

    function automatic vec_t mk(input logic rdy, input logic ie, input int ird, input int itag,
                                input logic ce, input int crd, input int ctag, input logic [31:0] cval,
                                input logic clr,
                                input int s1, input logic b1, input int t1, input logic [31:0] v1,
                                input int s2, input logic b2, input int t2, input logic [31:0] v2);
        vec_t v;
        v.rdy = rdy; v.ie = ie; v.ird = 5'(ird); v.itag = 4'(itag);
        v.ce = ce; v.crd = 5'(crd); v.ctag = 4'(ctag); v.cval = cval; v.clr = clr;
        v.s1 = 5'(s1); v.b1 = b1; v.t1 = 4'(t1); v.v1 = v1;
        v.s2 = 5'(s2); v.b2 = b2; v.t2 = 4'(t2); v.v2 = v2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        rdy_in = 1'b1; issue_en = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_en = 1'b0; commit_reg_id = '0; commit_rob_id = '0; commit_value = '0;
        clear_all = 1'b0; rs1_id = '0; rs2_id = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        drive_idle();
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_value[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    // Expected read for source s straight from the read rules: x0, exact
    // commit forwarding, pending tag, else committed value.
    function automatic logic [36:0] model_read(input logic [4:0] s);
        if (s == 0) return '0;
        if (commit_en && rdy_in && commit_reg_id == s && m_busy[s] && m_tag[s] == commit_rob_id)
            return {1'b0, 4'd0, commit_value};
        if (m_busy[s]) return {1'b1, m_tag[s], 32'd0};
        return {1'b0, 4'd0, m_value[s]};
    endfunction

    // Apply the architectural effect of the current inputs at a clock edge.
    task automatic model_edge();
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_value[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy_in) begin
            if (commit_en && commit_reg_id != 0) begin
                m_value[commit_reg_id] = commit_value;
                if (m_busy[commit_reg_id] && m_tag[commit_reg_id] == commit_rob_id)
                    m_busy[commit_reg_id] = 1'b0;
            end
            if (clear_all) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (issue_en && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                m_tag[issue_rd]  = issue_rob_id;
            end
        end
    endtask

    initial begin
        logic [36:0] e1;
        logic [36:0] e2;

        drive_idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        do_reset();

        // ---------------- directed vector table ----------------
        // reset state and x0 write
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  5,0,0,0,        31,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,32'hDEAD,   0,  0,0,0,0,         0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  0,0,0,0,         0,0,0,0));
        // issue then commit with bypass
        vecs.push_back(mk(1,1,3,2, 0,0,0,0,          0,  3,0,0,0,         0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  3,1,2,0,         3,1,2,0));
        vecs.push_back(mk(1,0,0,0, 1,3,2,32'h1234,   0,  3,0,0,32'h1234,  3,0,0,32'h1234));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  3,0,0,32'h1234,  0,0,0,0));
        // stale commit
        vecs.push_back(mk(1,1,4,1, 0,0,0,0,          0,  4,0,0,0,         0,0,0,0));
        vecs.push_back(mk(1,1,4,5, 0,0,0,0,          0,  4,1,1,0,         0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,4,1,7,          0,  4,1,5,0,         4,1,5,0));
        vecs.push_back(mk(1,0,0,0, 1,4,5,9,          0,  4,0,0,9,         0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  4,0,0,9,         0,0,0,0));
        // same-cycle issue and commit
        vecs.push_back(mk(1,1,6,3, 0,0,0,0,          0,  6,0,0,0,         0,0,0,0));
        vecs.push_back(mk(1,1,6,4, 1,6,3,32'hAA,     0,  6,0,0,32'hAA,    0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  6,1,4,0,         0,0,0,0));
        // flush with a same-cycle issue
        vecs.push_back(mk(1,1,1,0, 0,0,0,0,          0,  1,0,0,0,         0,0,0,0));
        vecs.push_back(mk(1,1,2,1, 0,0,0,0,          0,  1,1,0,0,         2,0,0,0));
        vecs.push_back(mk(1,1,7,2, 0,0,0,0,          0,  2,1,1,0,         7,0,0,0));
        vecs.push_back(mk(1,1,8,3, 0,0,0,0,          1,  7,1,2,0,         8,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  1,0,0,0,         2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  7,0,0,0,         8,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,          0,  6,0,0,32'hAA,    3,0,0,32'h1234));
        // rdy_in low holds state and suppresses bypass
        vecs.push_back(mk(1,1,10,7, 0,0,0,0,         0, 10,0,0,0,         0,0,0,0));
        vecs.push_back(mk(0,1,9,6,  1,10,7,5,        0, 10,1,7,0,         9,0,0,0));
        vecs.push_back(mk(0,1,9,6,  1,10,7,5,        0, 10,1,7,0,         9,0,0,0));
        vecs.push_back(mk(1,1,9,6,  1,10,7,5,        0, 10,0,0,5,         9,0,0,0));
        vecs.push_back(mk(1,0,0,0,  0,0,0,0,         0, 10,0,0,5,         9,1,6,0));
        // flush together with a stale-tag commit still writes the value
        vecs.push_back(mk(1,1,11,8, 0,0,0,0,         0, 11,0,0,0,         0,0,0,0));
        vecs.push_back(mk(1,0,0,0,  1,11,9,32'h55,   1, 11,1,8,0,         0,0,0,0));
        vecs.push_back(mk(1,0,0,0,  0,0,0,0,         0, 11,0,0,32'h55,    9,0,0,0));

        foreach (vecs[k]) begin
            @(negedge clk_in);
            rdy_in = vecs[k].rdy; issue_en = vecs[k].ie; issue_rd = vecs[k].ird;
            issue_rob_id = vecs[k].itag; commit_en = vecs[k].ce; commit_reg_id = vecs[k].crd;
            commit_rob_id = vecs[k].ctag; commit_value = vecs[k].cval; clear_all = vecs[k].clr;
            rs1_id = vecs[k].s1; rs2_id = vecs[k].s2;
            #1;
            check($sformatf("vec%0d rs1_busy", k),    32'(rs1_busy),    32'(vecs[k].b1));
            check($sformatf("vec%0d rs1_reorder", k), 32'(rs1_reorder), 32'(vecs[k].t1));
            check($sformatf("vec%0d rs1_value", k),   rs1_value,        vecs[k].v1);
            check($sformatf("vec%0d rs2_busy", k),    32'(rs2_busy),    32'(vecs[k].b2));
            check($sformatf("vec%0d rs2_reorder", k), 32'(rs2_reorder), 32'(vecs[k].t2));
            check($sformatf("vec%0d rs2_value", k),   rs2_value,        vecs[k].v2);
        end

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] r;
            @(negedge clk_in);
            rdy_in       = ($urandom_range(0, 7) != 0);
            issue_en     = $urandom_range(0, 1) == 1;
            issue_rd     = 5'($urandom_range(0, 7));
            issue_rob_id = 4'($urandom);
            clear_all    = ($urandom_range(0, 15) == 0);
            commit_en    = $urandom_range(0, 1) == 1;
            r            = 5'($urandom_range(0, 7));
            commit_reg_id = r;
            commit_rob_id = ($urandom_range(0, 3) != 0) ? m_tag[r] : 4'($urandom);
            commit_value  = $urandom;
            rs1_id = ($urandom_range(0, 1) == 1) ? r : 5'($urandom_range(0, 7));
            rs2_id = 5'($urandom_range(0, 31));
            #1;
            e1 = model_read(rs1_id);
            e2 = model_read(rs2_id);
            check("rnd rs1_busy",    32'(rs1_busy),    32'(e1[36]));
            check("rnd rs1_reorder", 32'(rs1_reorder), 32'(e1[35:32]));
            check("rnd rs1_value",   rs1_value,        e1[31:0]);
            check("rnd rs2_busy",    32'(rs2_busy),    32'(e2[36]));
            check("rnd rs2_reorder", 32'(rs2_reorder), 32'(e2[35:32]));
            check("rnd rs2_value",   rs2_value,        e2[31:0]);
            @(posedge clk_in);
            model_edge();
        end

        // ---------------- reset mid-operation overrides everything ----------------
        @(negedge clk_in);
        for (int i = 1; i < 8; i++) begin
            m_busy[i] = 1'b0;
        end
        rst_in = 1'b1; rdy_in = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd5; issue_rob_id = 4'd3;
        commit_en = 1'b1; commit_reg_id = 5'd6; commit_value = 32'hFFFF; clear_all = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        drive_idle();
        rst_in = 1'b0;
        for (int i = 1; i < 8; i++) begin
            rs1_id = 5'(i);
            rs2_id = 5'(i + 24);
            #1;
            check($sformatf("rst x%0d busy", i),  32'(rs1_busy),    32'd0);
            check($sformatf("rst x%0d tag", i),   32'(rs1_reorder), 32'd0);
            check($sformatf("rst x%0d value", i), rs1_value,        32'd0);
            check($sformatf("rst x%0d value", i + 24), rs2_value,   32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
